// File: rtl/go_pkg.sv
// Shared board definitions for the board receive path and the bus/array
// converter: board geometry, cell encodings, framing defaults, cell checks.
package go_pkg;

    localparam int BOARD_DIM  = 9;
    localparam int CELL_W     = 2;
    localparam int BOARD_BITS = BOARD_DIM * BOARD_DIM * CELL_W;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [CELL_W-1:0] {
        EMPTY   = 2'b00,
        BLACK   = 2'b01,
        WHITE   = 2'b10,
        INVALID = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CSUM    = 2'd2
    } rx_state_t;

    // True when any of the four 2-bit fields of the byte carries the
    // reserved code 11.
    function automatic logic byte_has_invalid_cell(input logic [7:0] b);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < 8 / CELL_W; k++) begin
            if (cell_t'(b[k*CELL_W +: CELL_W]) == INVALID) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/board_rx_assembler.sv
// Framed byte stream to packed 9x9 board bus. Hunts for the sync byte,
// shifts in the payload MSB first, checks cell codes, pad bits and the XOR
// checksum, and only then publishes the new board. A stalled frame is
// abandoned after TIMEOUT_CYCLES idle cycles.
module board_rx_assembler
    import go_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         PAYLOAD_BYTES  = 21,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid_in,
    output logic [BOARD_BITS-1:0] board_out,
    output logic                  board_valid_out,
    output logic                  frame_err_out,
    output logic                  busy_out
);

    localparam int                IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
    localparam logic [4:0]        LAST_IDX   = 5'(PAYLOAD_BYTES - 1);

    rx_state_t             state;
    logic [BOARD_BITS-1:0] asm_bus;
    logic [4:0]            count;
    logic [7:0]            csum;
    logic                  bad_cell;
    logic                  bad_pad;
    logic [IDLE_W-1:0]     idle;

    logic                  last_byte;
    logic                  cell_bad;
    logic                  pad_bad;
    logic [IDLE_W-1:0]     idle_next;
    logic                  timeout_hit;
    logic                  frame_good;

    // Per-byte checks and idle-timer bookkeeping for the current cycle.
    // The final payload byte carries a single cell in [7:6]; the rest is pad.
    always_comb begin
        last_byte   = (count == LAST_IDX);
        cell_bad    = last_byte ? byte_has_invalid_cell({byte_in[7:6], 6'b0})
                                : byte_has_invalid_cell(byte_in);
        pad_bad     = last_byte && (byte_in[5:0] != 6'd0);
        idle_next   = (idle == IDLE_LIMIT) ? idle : idle + IDLE_ONE;
        timeout_hit = !byte_valid_in && (idle_next == IDLE_LIMIT);
        frame_good  = (byte_in == csum) && !bad_cell && !bad_pad;
    end

    // Framing FSM with assembly register, running checksum and idle timer;
    // all outputs are registered and pulses last exactly one cycle.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state           <= HUNT;
            asm_bus         <= '0;
            count           <= 5'd0;
            csum            <= 8'd0;
            bad_cell        <= 1'b0;
            bad_pad         <= 1'b0;
            idle            <= '0;
            board_out       <= '0;
            board_valid_out <= 1'b0;
            frame_err_out   <= 1'b0;
            busy_out        <= 1'b0;
        end else begin
            board_valid_out <= 1'b0;
            frame_err_out   <= 1'b0;
            case (state)
                HUNT: begin
                    // Anything other than the sync byte is line noise here.
                    if (byte_valid_in && (byte_in == SYNC_BYTE)) begin
                        state    <= PAYLOAD;
                        busy_out <= 1'b1;
                        count    <= 5'd0;
                        csum     <= 8'd0;
                        bad_cell <= 1'b0;
                        bad_pad  <= 1'b0;
                        idle     <= '0;
                    end
                end
                PAYLOAD: begin
                    if (byte_valid_in) begin
                        // Full bytes shift in whole; the last byte only
                        // contributes its cell bits so the register lines up
                        // exactly with the 162-bit board bus.
                        if (last_byte) begin
                            asm_bus <= {asm_bus[BOARD_BITS-3:0], byte_in[7:6]};
                            state   <= CSUM;
                        end else begin
                            asm_bus <= {asm_bus[BOARD_BITS-9:0], byte_in};
                        end
                        csum  <= csum ^ byte_in;
                        count <= count + 5'd1;
                        idle  <= '0;
                        if (cell_bad) begin
                            bad_cell <= 1'b1;
                        end
                        if (pad_bad) begin
                            bad_pad <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        frame_err_out <= 1'b1;
                        state         <= HUNT;
                        busy_out      <= 1'b0;
                        count         <= 5'd0;
                        idle          <= '0;
                    end else begin
                        idle <= idle_next;
                    end
                end
                CSUM: begin
                    if (byte_valid_in) begin
                        if (frame_good) begin
                            board_out       <= asm_bus;
                            board_valid_out <= 1'b1;
                        end else begin
                            frame_err_out <= 1'b1;
                        end
                        state    <= HUNT;
                        busy_out <= 1'b0;
                        count    <= 5'd0;
                        idle     <= '0;
                    end else if (timeout_hit) begin
                        frame_err_out <= 1'b1;
                        state         <= HUNT;
                        busy_out      <= 1'b0;
                        count         <= 5'd0;
                        idle          <= '0;
                    end else begin
                        idle <= idle_next;
                    end
                end
                default: begin
                    state    <= HUNT;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_rx_assembler.sv
// Directed bench for board_rx_assembler with a short idle timeout.
module tb_board_rx_assembler;

    logic         clk_in = 1'b0;
    logic         rst_n;
    logic [7:0]   byte_in;
    logic         byte_valid_in;
    logic [161:0] board_out;
    logic         board_valid_out;
    logic         frame_err_out;
    logic         busy_out;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [161:0] BRD_ZERO   = 162'd0;
    localparam logic [161:0] BRD_BLK_88 = 162'd1 << 160;
    localparam logic [161:0] BRD_WHT_00 = 162'd2;
    localparam logic [161:0] BRD_B19    = 162'h90;

    always #5 clk_in = ~clk_in;

    board_rx_assembler #(
        .SYNC_BYTE     (8'hA5),
        .PAYLOAD_BYTES (21),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .byte_in        (byte_in),
        .byte_valid_in  (byte_valid_in),
        .board_out      (board_out),
        .board_valid_out(board_valid_out),
        .frame_err_out  (frame_err_out),
        .busy_out       (busy_out)
    );

    task automatic check(input string tag, input logic [161:0] obs, input logic [161:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic status(input string tag, input logic v, input logic e, input logic b);
        check({tag, ".valid"}, {161'd0, board_valid_out}, {161'd0, v});
        check({tag, ".err"},   {161'd0, frame_err_out},   {161'd0, e});
        check({tag, ".busy"},  {161'd0, busy_out},        {161'd0, b});
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        byte_in       = b;
        byte_valid_in = 1'b1;
        @(negedge clk_in);
        byte_valid_in = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Payload: b0, 18 zero bytes, b19, b20, then checksum byte cs.
    task automatic send_payload(input logic [7:0] b0, input logic [7:0] b19,
                                input logic [7:0] b20, input logic [7:0] cs);
        send_byte(b0);
        for (int i = 1; i <= 18; i++) send_byte(8'h00);
        send_byte(b19);
        send_byte(b20);
        send_byte(cs);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b19,
                              input logic [7:0] b20, input logic [7:0] cs);
        send_byte(8'hA5);
        send_payload(b0, b19, b20, cs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        byte_in       = 8'h00;
        byte_valid_in = 1'b0;
        idle_cycles(3);
        check("reset.board", board_out, BRD_ZERO);
        status("reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle_cycles(1);

        // Stray bytes in HUNT are dropped silently.
        send_byte(8'h12);
        send_byte(8'h34);
        status("stray", 1'b0, 1'b0, 1'b0);

        // Black stone at [8][8].
        send_frame(8'h40, 8'h00, 8'h00, 8'h40);
        check("blk88.board", board_out, BRD_BLK_88);
        status("blk88", 1'b1, 1'b0, 1'b0);
        idle_cycles(1);
        status("blk88.after", 1'b0, 1'b0, 1'b0);

        // Invalid cell code 11 rejects the frame, board held.
        send_frame(8'hC0, 8'h00, 8'h00, 8'hC0);
        status("badcell", 1'b0, 1'b1, 1'b0);
        check("badcell.board", board_out, BRD_BLK_88);
        idle_cycles(1);
        check("badcell.err_off", {161'd0, frame_err_out}, 162'd0);

        // White stone at [0][0] via the last payload byte.
        send_frame(8'h00, 8'h00, 8'h80, 8'h80);
        check("wht00.board", board_out, BRD_WHT_00);
        status("wht00", 1'b1, 1'b0, 1'b0);
        idle_cycles(1);

        // Nonzero pad bits.
        send_frame(8'h00, 8'h00, 8'h01, 8'h01);
        status("pad", 1'b0, 1'b1, 1'b0);
        check("pad.board", board_out, BRD_WHT_00);
        idle_cycles(1);

        // Checksum mismatch.
        send_frame(8'h00, 8'h00, 8'h00, 8'hFF);
        status("csum", 1'b0, 1'b1, 1'b0);
        check("csum.board", board_out, BRD_WHT_00);
        idle_cycles(1);

        // All-zero good frame clears the board.
        send_frame(8'h00, 8'h00, 8'h00, 8'h00);
        check("zero.board", board_out, BRD_ZERO);
        status("zero", 1'b1, 1'b0, 1'b0);
        idle_cycles(1);

        // Timeout: sync plus 5 payload bytes, then 16 idle cycles.
        send_byte(8'hA5);
        send_byte(8'h40);
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        idle_cycles(15);
        status("tmo.pre", 1'b0, 1'b0, 1'b1);
        idle_cycles(1);
        status("tmo.hit", 1'b0, 1'b1, 1'b0);
        check("tmo.board", board_out, BRD_ZERO);
        idle_cycles(1);
        status("tmo.after", 1'b0, 1'b0, 1'b0);

        // A byte on the 16th idle cycle is accepted; frame then completes.
        send_byte(8'hA5);
        send_byte(8'h40);
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        idle_cycles(15);
        send_byte(8'h00);
        status("win", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) send_byte(8'h00);
        send_byte(8'h40);
        check("win.board", board_out, BRD_BLK_88);
        status("win.done", 1'b1, 1'b0, 1'b0);
        idle_cycles(1);

        // Back-to-back frames: sync right after the checksum byte.
        send_frame(8'h00, 8'h00, 8'h00, 8'h00);
        check("b2b1.board", board_out, BRD_ZERO);
        status("b2b1", 1'b1, 1'b0, 1'b0);
        send_byte(8'hA5);
        status("b2b.sync", 1'b0, 1'b0, 1'b1);
        send_payload(8'h00, 8'h24, 8'h00, 8'h24);
        check("b2b2.board", board_out, BRD_B19);
        status("b2b2", 1'b1, 1'b0, 1'b0);
        idle_cycles(1);

        // Reset in the middle of a payload.
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        status("mid.busy", 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst.board", board_out, BRD_ZERO);
        status("rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk_in);
        rst_n = 1'b1;
        idle_cycles(2);
        status("rst.after", 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
